// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - instruction fields, memory handshake and datapath controls of mc_ctrl
interface mc_ctrl_if;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       mem_ready;
   logic       pc_write;
   logic       ir_write;
   logic       reg_write;
   logic       mem_write;
   logic       adr_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_control;
   logic [1:0] imm_src;
   logic [1:0] reg_src;
   logic [3:0] flags;
   logic [3:0] state;

   modport master (
      output cond, op, funct, rd, alu_flags, mem_ready,
      input  pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
             alu_src_b, result_src, alu_control, imm_src, reg_src, flags, state
   );

   modport slave (
      input  cond, op, funct, rd, alu_flags, mem_ready,
      output pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
             alu_src_b, result_src, alu_control, imm_src, reg_src, flags, state
   );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle control FSM with NZCV register and condition evaluation
module mc_ctrl (
   input  logic      clk,
   input  logic      reset_n,
   mc_ctrl_if.slave  bus
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q;
   logic       cond_ex_q, cond_ex_d;
   logic [3:0] cmd;
   logic       s_bit, is_cmp, upd_cv, rd_pc;
   logic [1:0] alu_dec;
   logic       pc_w, ir_w, reg_w, mem_w;

   assign cmd    = bus.funct[4:1];
   assign s_bit  = bus.funct[0];
   assign is_cmp = (cmd == 4'b1010);
   assign upd_cv = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
   assign rd_pc  = (bus.rd == 4'hf);

   always_comb begin
      case (cmd)
         4'b0100: alu_dec = 2'b00;
         4'b0010: alu_dec = 2'b01;
         4'b0000: alu_dec = 2'b10;
         4'b1100: alu_dec = 2'b11;
         4'b1010: alu_dec = 2'b01;
         default: alu_dec = 2'b00;
      endcase
   end

   // Flag order is N,Z,C,V from msb down.
   always_comb begin
      case (bus.cond)
         4'h0:    cond_ex_d = flags_q[2];
         4'h1:    cond_ex_d = !flags_q[2];
         4'h2:    cond_ex_d = flags_q[1];
         4'h3:    cond_ex_d = !flags_q[1];
         4'h4:    cond_ex_d = flags_q[3];
         4'h5:    cond_ex_d = !flags_q[3];
         4'h6:    cond_ex_d = flags_q[0];
         4'h7:    cond_ex_d = !flags_q[0];
         4'h8:    cond_ex_d = flags_q[1] && !flags_q[2];
         4'h9:    cond_ex_d = !flags_q[1] || flags_q[2];
         4'ha:    cond_ex_d = (flags_q[3] == flags_q[0]);
         4'hb:    cond_ex_d = (flags_q[3] != flags_q[0]);
         4'hc:    cond_ex_d = !flags_q[2] && (flags_q[3] == flags_q[0]);
         4'hd:    cond_ex_d = flags_q[2] || (flags_q[3] != flags_q[0]);
         4'he:    cond_ex_d = 1'b1;
         default: cond_ex_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         flags_q   <= 4'h0;
         cond_ex_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            cond_ex_q <= cond_ex_d;
         if ((state_q == S_EXECR || state_q == S_EXECI) && s_bit && cond_ex_q) begin
            flags_q[3:2] <= bus.alu_flags[3:2];
            if (upd_cv)
               flags_q[1:0] <= bus.alu_flags[1:0];
         end
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.op)
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               2'b00:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_w            = 1'b0;
      ir_w            = 1'b0;
      reg_w           = 1'b0;
      mem_w           = 1'b0;
      bus.adr_src     = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = 2'b00;
      bus.result_src  = 2'b00;
      bus.alu_control = 2'b00;
      case (state_q)
         S_FETCH, S_DECODE: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            if (state_q == S_FETCH) begin
               pc_w = bus.mem_ready;
               ir_w = bus.mem_ready;
            end
         end
         S_MEMADR:   bus.alu_src_b = 2'b01;
         S_MEMREAD:  bus.adr_src = 1'b1;
         S_MEMWRITE: begin
            bus.adr_src = 1'b1;
            mem_w       = bus.mem_ready && cond_ex_q;
         end
         S_MEMWB: begin
            bus.result_src = 2'b01;
            reg_w          = cond_ex_q;
            pc_w           = cond_ex_q && rd_pc;
         end
         S_EXECR:    bus.alu_control = alu_dec;
         S_EXECI: begin
            bus.alu_src_b   = 2'b01;
            bus.alu_control = alu_dec;
         end
         S_ALUWB: begin
            reg_w = cond_ex_q && !is_cmp;
            pc_w  = cond_ex_q && !is_cmp && rd_pc;
         end
         S_BRANCH: begin
            bus.alu_src_b  = 2'b01;
            bus.result_src = 2'b10;
            pc_w           = cond_ex_q;
         end
         default: ;
      endcase
   end

   // Enables are held low for the whole reset pulse, not just after the edge.
   assign bus.pc_write  = pc_w && reset_n;
   assign bus.ir_write  = ir_w && reset_n;
   assign bus.reg_write = reg_w && reset_n;
   assign bus.mem_write = mem_w && reset_n;
   assign bus.imm_src   = bus.op;
   assign bus.reg_src   = {bus.op == 2'b01, bus.op == 2'b10};
   assign bus.flags     = flags_q;
   assign bus.state     = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl using directed instruction sequences
module tb_mc_ctrl;
   logic clk;
   logic reset_n;
   mc_ctrl_if bus ();

   mc_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] en;
      logic [3:0] fl;
      logic [6:0] sel;
      logic [3:0] isr;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         passes = 0;
   int         ncyc = 0;
   logic [3:0] exp_fl = 4'h0;
   logic [3:0] exp_isr = 4'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {adr_src, alu_src_b, result_src, alu_control} expected for each state
   function automatic logic [6:0] sel_of(input logic [3:0] st, input logic [1:0] ac);
      case (st)
         4'd0, 4'd1: sel_of = 7'b0_10_10_00;
         4'd2:       sel_of = 7'b0_01_00_00;
         4'd3, 4'd5: sel_of = 7'b1_00_00_00;
         4'd4:       sel_of = 7'b0_00_01_00;
         4'd6:       sel_of = {5'b0_00_00, ac};
         4'd7:       sel_of = {5'b0_01_00, ac};
         4'd9:       sel_of = 7'b0_01_10_00;
         default:    sel_of = 7'b0_00_00_00;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, ncyc, act, exp);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("state", int'(bus.state), int'(e.st));
         chk("enables", int'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}), int'(e.en));
         chk("flags", int'(bus.flags), int'(e.fl));
         chk("selects", int'({bus.adr_src, bus.alu_src_b, bus.result_src, bus.alu_control}), int'(e.sel));
         chk("imm_reg_src", int'({bus.imm_src, bus.reg_src}), int'(e.isr));
         ncyc++;
      end
   end

   task automatic cyc(input logic [3:0] st, input logic [3:0] en, input logic [1:0] ac);
      exp_t e;
      e.st  = st;
      e.en  = en;
      e.fl  = exp_fl;
      e.sel = sel_of(st, ac);
      e.isr = exp_isr;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                        input logic [3:0] r, input logic [3:0] af);
      bus.cond      = c;
      bus.op        = o;
      bus.funct     = f;
      bus.rd        = r;
      bus.alu_flags = af;
      exp_isr       = {o, o == 2'b01, o == 2'b10};
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.mem_ready = 1'b1;
      instr(4'he, 2'b00, 6'b000000, 4'd0, 4'h0);
      @(posedge clk);
      #1;
      cyc(4'd0, 4'b0000, 2'b00);
      cyc(4'd0, 4'b0000, 2'b00);
      reset_n = 1'b1;

      // ADD immediate, AL
      instr(4'he, 2'b00, 6'b101000, 4'd1, 4'h0);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd7, 4'b0000, 2'b00); cyc(4'd8, 4'b0010, 2'b00);

      // ADDSEQ with Z=0: suppressed write and flag update
      instr(4'h0, 2'b00, 6'b001001, 4'd1, 4'hf);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd6, 4'b0000, 2'b00); cyc(4'd8, 4'b0000, 2'b00);

      // SUBS giving Z, then BEQ taken
      instr(4'he, 2'b00, 6'b000101, 4'd2, 4'h4);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd6, 4'b0000, 2'b01); exp_fl = 4'h4; cyc(4'd8, 4'b0010, 2'b00);
      instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00); cyc(4'd9, 4'b1000, 2'b00);

      // SUBS giving zero flags, then BEQ not taken
      instr(4'he, 2'b00, 6'b000101, 4'd2, 4'h0);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd6, 4'b0000, 2'b01); exp_fl = 4'h0; cyc(4'd8, 4'b0010, 2'b00);
      instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00); cyc(4'd9, 4'b0000, 2'b00);

      // CMP sets NV, no register write
      instr(4'he, 2'b00, 6'b010101, 4'd0, 4'h9);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd6, 4'b0000, 2'b01); exp_fl = 4'h9; cyc(4'd8, 4'b0000, 2'b00);

      // ANDS loads N,Z only: C,V kept from CMP
      instr(4'he, 2'b00, 6'b000001, 4'd4, 4'h6);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd6, 4'b0000, 2'b10); exp_fl = 4'h5; cyc(4'd8, 4'b0010, 2'b00);

      // ORR immediate to r15: pc_write in ALUWB
      instr(4'he, 2'b00, 6'b111000, 4'd15, 4'h0);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd7, 4'b0000, 2'b11); cyc(4'd8, 4'b1010, 2'b00);

      // LDR with three wait states, rd=3 then rd=15
      for (int k = 0; k < 2; k++) begin
         instr(4'he, 2'b01, 6'b011001, (k == 0) ? 4'd3 : 4'd15, 4'h0);
         cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00); cyc(4'd2, 4'b0000, 2'b00);
         bus.mem_ready = 1'b0;
         cyc(4'd3, 4'b0000, 2'b00); cyc(4'd3, 4'b0000, 2'b00); cyc(4'd3, 4'b0000, 2'b00);
         bus.mem_ready = 1'b1;
         cyc(4'd3, 4'b0000, 2'b00);
         cyc(4'd4, (k == 0) ? 4'b0010 : 4'b1010, 2'b00);
      end

      // STRNE with Z=1 and a fetch wait state: no mem_write
      instr(4'h1, 2'b01, 6'b011000, 4'd5, 4'h0);
      bus.mem_ready = 1'b0;
      cyc(4'd0, 4'b0000, 2'b00);
      bus.mem_ready = 1'b1;
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd2, 4'b0000, 2'b00); cyc(4'd5, 4'b0000, 2'b00);

      // STR AL writes memory
      instr(4'he, 2'b01, 6'b011000, 4'd5, 4'h0);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00);
      cyc(4'd2, 4'b0000, 2'b00); cyc(4'd5, 4'b0001, 2'b00);

      // STR interrupted by reset in MEMWRITE
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00); cyc(4'd2, 4'b0000, 2'b00);
      bus.mem_ready = 1'b0;
      cyc(4'd5, 4'b0000, 2'b00);
      reset_n       = 1'b0;
      bus.mem_ready = 1'b1;
      exp_fl        = 4'h0;
      cyc(4'd0, 4'b0000, 2'b00);
      reset_n = 1'b1;

      // Undefined op=11 returns from DECODE to FETCH
      instr(4'he, 2'b11, 6'b000000, 4'd0, 4'h0);
      cyc(4'd0, 4'b1100, 2'b00); cyc(4'd1, 4'b0000, 2'b00); cyc(4'd0, 4'b1100, 2'b00);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain actual=%0d expected=0", sb.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
